// File: rtl/tlc_sync_master.sv
// Head-of-chain sync initiator for the traffic-light controller serial link.
// Sends one green-duration word, then times its return through the chain.
module tlc_sync_master #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] Ml,
    output logic [6:0] serialOut,
    input  logic [6:0] serialIn,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       timeout,
    output logic [5:0] latency
);

    localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] ml_q, ml_d;
    logic [5:0] cnt_q, cnt_d;
    logic [6:0] serial_out_q, serial_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       timeout_q, timeout_d;
    logic [5:0] latency_q, latency_d;

    always_comb begin
        state_d      = state_q;
        ml_d         = ml_q;
        cnt_d        = cnt_q;
        serial_out_d = 7'd0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        timeout_d    = 1'b0;
        latency_d    = latency_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ml_d         = Ml;
                    serial_out_d = {1'b1, Ml};
                    busy_d       = 1'b1;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                // Counter restarts at 0 and is bumped on entry to WAIT, so WAIT cycle 1 sees 1.
                cnt_d   = 6'd1;
                busy_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (serialIn[6]) begin
                    if (serialIn[5:0] == ml_q) begin
                        done_d    = 1'b1;
                        latency_d = cnt_q;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d  = cnt_q + 6'd1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ml_q         <= 6'd0;
            cnt_q        <= 6'd0;
            serial_out_q <= 7'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            latency_q    <= 6'd0;
        end else begin
            state_q      <= state_d;
            ml_q         <= ml_d;
            cnt_q        <= cnt_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            latency_q    <= latency_d;
        end
    end

    assign serialOut = serial_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign timeout   = timeout_q;
    assign latency   = latency_q;

endmodule

// File: tb/tb_tlc_sync_master.sv
// Directed bench for tlc_sync_master: a programmable delay line models the
// controller chain between serialOut and serialIn.
module tb_tlc_sync_master;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] Ml;
    logic [6:0] serialOut;
    logic [6:0] serialIn;
    logic       busy, done, error, timeout;
    logic [5:0] latency;

    int         nchk = 0;
    int         nerr = 0;

    logic       force_en;
    logic [6:0] force_val;
    int         depth;
    logic       corrupt;
    logic [6:0] dly [0:15] = '{default: 7'd0};

    tlc_sync_master #(.TIMEOUT(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .Ml        (Ml),
        .serialOut (serialOut),
        .serialIn  (serialIn),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .timeout   (timeout),
        .latency   (latency)
    );

    always #5 clock = ~clock;

    // Chain model: word re-appears on serialIn 'depth' cycles after it left serialOut
    always @(posedge clock) begin
        dly[0] <= serialOut;
        for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
    end

    always_comb begin
        serialIn = 7'd0;
        if (force_en) begin
            serialIn = force_val;
        end else if (depth > 0) begin
            serialIn = dly[depth-1];
            if (corrupt && serialIn[6]) serialIn[5:0] = 6'd16;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input int d, input logic c);
        depth   = d;
        corrupt = c;
        repeat (16) tick();
    endtask

    initial begin
        int   vcount;
        int   bc;
        logic got;
        logic seen;

        // Reset held with hostile inputs
        reset = 1'b0; start = 1'b1; Ml = 6'h3F;
        force_en = 1'b1; force_val = 7'h7F; depth = 0; corrupt = 1'b0;
        repeat (3) tick();
        check("rst_serialOut", 32'(serialOut), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        check("rst_latency",   32'(latency),   32'd0);
        reset = 1'b1; start = 1'b0; force_en = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        tick();
        check("post_rst_serialOut", 32'(serialOut), 32'd0);

        // One-flop loopback, Ml=8
        setup(1, 1'b0);
        Ml = 6'b001000; start = 1'b1;
        tick();
        check("lb1_send_word", 32'(serialOut), 32'h48);
        check("lb1_send_busy", 32'(busy), 32'd1);
        start = 1'b0;
        tick();
        check("lb1_wait_word", 32'(serialOut), 32'd0);
        check("lb1_wait_busy", 32'(busy), 32'd1);
        tick();
        check("lb1_done",    32'(done),    32'd1);
        check("lb1_latency", 32'(latency), 32'd1);
        check("lb1_busy_lo", 32'(busy),    32'd0);
        tick();
        check("lb1_done_pulse", 32'(done), 32'd0);

        // Ml=0 payload, then a start accepted in the done cycle
        setup(1, 1'b0);
        Ml = 6'd0; start = 1'b1;
        tick();
        check("ml0_word", 32'(serialOut), 32'h40);
        start = 1'b0;
        tick(); tick();
        check("ml0_done", 32'(done), 32'd1);
        Ml = 6'd5; start = 1'b1;
        tick();
        check("b2b_word", 32'(serialOut), 32'h45);
        start = 1'b0;
        tick(); tick();
        check("b2b_done",    32'(done),    32'd1);
        check("b2b_latency", 32'(latency), 32'd1);

        // 5-stage loopback with an ignored second start
        setup(5, 1'b0);
        Ml = 6'd17; start = 1'b1;
        tick();
        vcount = serialOut[6] ? 1 : 0;
        got = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            start = (j == 2);
            tick();
            if (serialOut[6]) vcount++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("d5_done",    32'(got),     32'd1);
        check("d5_latency", 32'(latency), 32'd5);
        check("d5_words",   32'(vcount),  32'd1);
        check("d5_error",   32'(error),   32'd0);

        // No return: timeout after 10 WAIT cycles
        setup(0, 1'b0);
        Ml = 6'd9; start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0; got = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (busy) bc++;
            if (timeout) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("to_pulse",   32'(got),     32'd1);
        check("to_busy",    32'(bc),      32'd11);
        check("to_latency", 32'(latency), 32'd5);
        check("to_done",    32'(done),    32'd0);
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);

        // Return on the last WAIT cycle wins over timeout
        setup(10, 1'b0);
        Ml = 6'd42; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 30; j++) begin
            tick();
            if (done || error || timeout) break;
        end
        check("edge_done",    32'(done),    32'd1);
        check("edge_timeout", 32'(timeout), 32'd0);
        check("edge_latency", 32'(latency), 32'd10);

        // Corrupted return payload
        setup(1, 1'b1);
        Ml = 6'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("err_pulse",   32'(error),   32'd1);
        check("err_done",    32'(done),    32'd0);
        check("err_timeout", 32'(timeout), 32'd0);
        check("err_latency", 32'(latency), 32'd10);
        tick();
        check("err_pulse_end", 32'(error), 32'd0);

        // Reset during WAIT cycle 3; the late word must be ignored
        setup(6, 1'b0);
        Ml = 6'd33; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy",    32'(busy),    32'd0);
        check("mid_rst_latency", 32'(latency), 32'd0);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (done || error || timeout || busy) seen = 1'b1;
        end
        check("mid_late_ignored", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
